// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable N-bit pattern, overlap mode,
// a registered one-cycle match pulse and a saturating match counter.
module seq_detect_param #(
  parameter int             N           = 4,
  parameter logic [N-1:0]   RST_PATTERN = N'(4'b1101),
  parameter bit             RST_OVERLAP = 1'b1,
  parameter int             CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [N-1:0]     cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int             FW   = $clog2(N + 1);
  localparam logic [FW-1:0]  FULL = FW'(N);

  // Only the newest N-1 bits are kept: the oldest bit of an N-bit history is
  // shifted out before it could ever take part in a comparison.
  logic [N-2:0]     hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [N-1:0]     pat_q, pat_d;
  logic             ovl_q, ovl_d;
  logic             y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N-1:0]     samp;
  logic [FW-1:0]    fill_inc;
  logic             match;

  always_comb begin
    samp     = {hist_q, a};
    fill_inc = (fill_q == FULL) ? FULL : fill_q + 1'b1;
    match    = in_valid && !cfg_load && (fill_inc == FULL) && (samp == pat_q);

    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    ovl_d  = ovl_q;
    y_d    = 1'b0;
    cnt_d  = cnt_q;

    if (cfg_load) begin
      pat_d  = cfg_pattern;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = samp[N-2:0];
      fill_d = (match && !ovl_q) ? '0 : fill_inc;
      y_d    = match;
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= RST_PATTERN;
      ovl_q  <= RST_OVERLAP;
      y_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      ovl_q  <= ovl_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
    end
  end

  assign y         = y_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = &cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: a sliding-window reference model
// predicts y/match_cnt/cnt_sat for a CNT_W=8 and a CNT_W=2 instance.
module tb_seq_detect_param;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         a = 1'b0, in_valid = 1'b0, cfg_load = 1'b0, cfg_overlap = 1'b0, cnt_clr = 1'b0;
  logic [N-1:0] cfg_pattern = '0;
  logic         y8, sat8, y2, sat2;
  logic [7:0]   cnt8;
  logic [1:0]   cnt2;

  seq_detect_param u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .y(y8), .match_cnt(cnt8), .cnt_sat(sat8)
  );

  seq_detect_param #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .y(y2), .match_cnt(cnt2), .cnt_sat(sat2)
  );

  always #5 clk = ~clk;

  typedef struct { bit y; int c8; int c2; } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: recent samples since the last restart of matching.
  bit           win[$];
  logic [N-1:0] mpat;
  bit           movl;
  int           m8, m2;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    win.delete();
    sb.delete();
    mpat = 4'b1101;
    movl = 1'b1;
    m8 = 0;
    m2 = 0;
  endtask

  task automatic step(input bit ai, input bit vi, input bit ldi,
                      input logic [N-1:0] pi, input bit oi, input bit clri);
    exp_t         e;
    logic [N-1:0] w;
    @(negedge clk);
    a = ai; in_valid = vi; cfg_load = ldi; cfg_pattern = pi; cfg_overlap = oi; cnt_clr = clri;
    e.y = 1'b0;
    if (ldi) begin
      mpat = pi;
      movl = oi;
      win.delete();
    end else if (vi) begin
      win.push_back(ai);
      if (win.size() > N) void'(win.pop_front());
      if (win.size() == N) begin
        w = '0;
        foreach (win[i]) w = {w[N-2:0], win[i]};
        if (w == mpat) begin
          e.y = 1'b1;
          if (!movl) win.delete();
        end
      end
    end
    if (clri) begin
      m8 = 0;
      m2 = 0;
    end else if (e.y) begin
      if (m8 < 255) m8++;
      if (m2 < 3) m2++;
    end
    e.c8 = m8;
    e.c2 = m2;
    sb.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic feed(input logic [31:0] bits, input int n, input bit gaps);
    logic [31:0] b;
    b = bits;
    for (int i = n - 1; i >= 0; i--) begin
      step(b[i], 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
      if (gaps) begin
        idle();
        idle();
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a = 1'b0; in_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0; cfg_overlap = 1'b0; cfg_pattern = '0;
    #1;
    chk("rst_y8", int'(y8), 0);
    chk("rst_cnt8", int'(cnt8), 0);
    chk("rst_sat8", int'(sat8), 0);
    chk("rst_cnt2", int'(cnt2), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one expected response per stimulus cycle, checked after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && sb.size() > 0) begin
      e = sb.pop_front();
      chk("y8", int'(y8), int'(e.y));
      chk("cnt8", int'(cnt8), e.c8);
      chk("sat8", int'(sat8), int'(e.c8 == 255));
      chk("y2", int'(y2), int'(e.y));
      chk("cnt2", int'(cnt2), e.c2);
      chk("sat2", int'(sat2), int'(e.c2 == 3));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    model_reset();
    do_reset();

    feed(32'b1101, 4, 1'b0);
    idle();

    do_reset();
    feed(32'b1101101, 7, 1'b0);
    idle();

    step(1'b0, 1'b0, 1'b1, 4'b1101, 1'b0, 1'b0);
    feed(32'b1101101, 7, 1'b0);
    idle();

    do_reset();
    feed(32'b1101, 4, 1'b1);

    do_reset();
    feed(32'b1101101101101101, 16, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    idle();

    feed(32'b110, 3, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
    feed(32'b110, 3, 1'b0);
    step(1'b1, 1'b1, 1'b1, 4'b1101, 1'b1, 1'b0);
    feed(32'b1101, 4, 1'b0);

    do_reset();
    feed(32'b110, 3, 1'b0);
    do_reset();
    feed(32'b1, 1, 1'b0);
    idle();

    step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 270; i++) step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
    idle();

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
             4'($urandom), 1'($urandom), $urandom_range(0, 29) == 0);
      end
    end

    idle();
    @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
